// File: rtl/i2c_tx_feeder.sv
// Byte FIFO in front of the I2C byte transmitter: releases a transaction only once its last byte
// is buffered, so the transmitter never runs dry mid-write.
module i2c_tx_feeder #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       wr_last,
  output logic       wr_full,
  input  logic       flush,
  output logic [7:0] tx_data,
  output logic       tx_data_ready,
  output logic       tx_en,
  input  logic       tx_data_req,
  input  logic       tx_done,
  output logic       busy,
  output logic       txn_done,
  output logic       overflow,
  output logic       deadlock
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2:0]   cnt_t;
  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef enum logic [1:0] {StIdle, StActive, StWaitDone} state_e;

  localparam cnt_t DepthCnt = cnt_t'(Depth);

  logic [8:0] mem [Depth];
  ptr_t       wr_ptr, rd_ptr;
  cnt_t       count, committed;
  state_e     state;
  logic       flush_pend, flush_pend_d;
  logic       tx_en_q, txn_done_q, overflow_q, deadlock_q;
  logic       clear, push, pop;
  logic [8:0] head;

  always_comb begin
    head          = mem[rd_ptr];
    wr_full       = (count == DepthCnt);
    tx_data_ready = (state == StActive) ||
                    ((state == StIdle) && (committed != '0) && !flush_pend);
    // A flush only takes effect from IDLE, so an in-flight transaction always completes.
    clear         = (state == StIdle) && (flush || flush_pend);
    push          = wr_en && !wr_full && !clear;
    pop           = tx_data_req && tx_data_ready && !clear;
    tx_data       = (count != '0) ? head[7:0] : 8'h00;
    busy          = (state != StIdle);
    flush_pend_d  = flush_pend;
    if (clear) begin
      flush_pend_d = 1'b0;
    end else if (flush && (state != StIdle)) begin
      flush_pend_d = 1'b1;
    end
  end

  assign tx_en    = tx_en_q;
  assign txn_done = txn_done_q;
  assign overflow = overflow_q;
  assign deadlock = deadlock_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {wr_last, wr_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      committed  <= '0;
      flush_pend <= 1'b0;
      tx_en_q    <= 1'b0;
      txn_done_q <= 1'b0;
      overflow_q <= 1'b0;
      deadlock_q <= 1'b0;
    end else begin
      flush_pend <= flush_pend_d;
      tx_en_q    <= !flush_pend_d;
      txn_done_q <= 1'b0;
      if (clear) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        committed  <= '0;
        overflow_q <= 1'b0;
        deadlock_q <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count     <= count + cnt_t'(push) - cnt_t'(pop);
        committed <= committed + cnt_t'(push && wr_last) - cnt_t'(pop && head[8]);
        if (wr_en && wr_full) overflow_q <= 1'b1;
        if (wr_full && (committed == '0)) deadlock_q <= 1'b1;
      end
      case (state)
        StIdle: begin
          if (pop) state <= head[8] ? StWaitDone : StActive;
        end
        StActive: begin
          if (pop && head[8]) state <= StWaitDone;
        end
        StWaitDone: begin
          if (tx_done) begin
            state      <= StIdle;
            txn_done_q <= 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_tx_feeder.sv
// Bench for i2c_tx_feeder: acts as the transmitter and checks every byte and flag against a
// queue-based model of the buffered transactions.
module tb_i2c_tx_feeder;

  localparam int Depth = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_last = 1'b0;
  logic       wr_full;
  logic       flush = 1'b0;
  logic [7:0] tx_data;
  logic       tx_data_ready;
  logic       tx_en;
  logic       tx_data_req = 1'b0;
  logic       tx_done = 1'b0;
  logic       busy;
  logic       txn_done;
  logic       overflow;
  logic       deadlock;

  int total = 0;
  int bad = 0;

  // Model: the bytes the FIFO should hold, plus the sticky flags.
  logic [8:0] q[$];
  bit ovf_m = 0;
  bit dl_m = 0;
  bit fpend_m = 0;

  i2c_tx_feeder #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last),
    .wr_full(wr_full), .flush(flush), .tx_data(tx_data), .tx_data_ready(tx_data_ready),
    .tx_en(tx_en), .tx_data_req(tx_data_req), .tx_done(tx_done), .busy(busy),
    .txn_done(txn_done), .overflow(overflow), .deadlock(deadlock)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ncommit();
    int n = 0;
    foreach (q[i]) if (q[i][8]) n++;
    return n;
  endfunction

  function automatic void model_clear();
    q.delete();
    ovf_m = 0;
    dl_m = 0;
    fpend_m = 0;
  endfunction

  task automatic tick();
    // Deadlock latches from the contents present before this edge.
    if (q.size() == Depth && ncommit() == 0) dl_m = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    wr_en = 1'b1;
    wr_data = d;
    wr_last = l;
    tick();
    wr_en = 1'b0;
    wr_last = 1'b0;
    if (q.size() < Depth) q.push_back({l, d});
    else ovf_m = 1;
    check_eq("wr_full", wr_full, q.size() == Depth);
    check_eq("push_ready", tx_data_ready, ncommit() != 0 && !fpend_m);
  endtask

  // Transmitter model: chain bytes while ready, then STOP and pulse tx_done.
  task automatic xmit(input int flush_after);
    int n = 0;
    int k = 0;
    bit done = 0;
    logic [8:0] e;
    while (!tx_data_ready && n < 50) begin
      tick();
      n++;
    end
    check_eq("start_ready", tx_data_ready, 1);
    if (!tx_data_ready || q.size() == 0) return;
    while (!done) begin
      e = q[0];
      check_eq("tx_data", tx_data, e[7:0]);
      tx_data_req = 1'b1;
      tick();
      tx_data_req = 1'b0;
      void'(q.pop_front());
      k++;
      if (e[8]) begin
        done = 1;
        check_eq("ready_after_last", tx_data_ready, 0);
        check_eq("busy_wait", busy, 1);
      end else begin
        check_eq("ready_mid", tx_data_ready, 1);
        if (k == flush_after) begin
          flush = 1'b1;
          tick();
          flush = 1'b0;
          fpend_m = 1;
          check_eq("tx_en_pend", tx_en, 0);
        end
        repeat ($urandom_range(3)) tick();
        if (q.size() == 0) done = 1;
      end
    end
    repeat (3) tick();
    check_eq("ready_wait", tx_data_ready, 0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check_eq("txn_done", txn_done, 1);
    check_eq("busy_idle", busy, 0);
    check_eq("ready_next", tx_data_ready, ncommit() != 0 && !fpend_m);
    tick();
    if (fpend_m) begin
      model_clear();
      check_eq("tx_en_clear", tx_en, 1);
      check_eq("flush_ready", tx_data_ready, 0);
      check_eq("flush_full", wr_full, 0);
    end
    check_eq("txn_done_pulse", txn_done, 0);
  endtask

  initial begin
    int len;
    tick();
    tick();
    check_eq("rst_ready", tx_data_ready, 0);
    check_eq("rst_tx_en", tx_en, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_full", wr_full, 0);
    check_eq("rst_tx_data", tx_data, 0);
    rst_n = 1'b1;
    tick();
    check_eq("tx_en_up", tx_en, 1);

    // 3-byte transaction
    push(8'h48, 0); push(8'h01, 0); push(8'hA5, 1);
    xmit(-1);

    // Withheld start
    push(8'h48, 0); push(8'h01, 0);
    repeat (200) tick();
    check_eq("withheld", tx_data_ready, 0);
    push(8'h02, 1);
    xmit(-1);

    // Back-to-back
    push(8'h48, 0); push(8'h10, 1); push(8'h90, 1);
    xmit(-1);
    xmit(-1);

    // Full FIFO, overflow, deadlock, flush in IDLE
    for (int i = 0; i < 17; i++) push(8'(i + 3), 0);
    check_eq("overflow", overflow, 1);
    check_eq("deadlock", deadlock, dl_m);
    check_eq("deadlock_set", deadlock, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    model_clear();
    check_eq("fl_full", wr_full, 0);
    check_eq("fl_ovf", overflow, 0);
    check_eq("fl_dl", deadlock, 0);
    check_eq("fl_ready", tx_data_ready, 0);

    // Flush during ACTIVE of a 4-byte transaction, next transaction buffered
    push(8'h11, 0); push(8'h22, 0); push(8'h33, 0); push(8'h44, 1);
    push(8'h66, 0); push(8'h77, 1);
    xmit(1);
    repeat (20) tick();
    check_eq("flushed_idle_ready", tx_data_ready, 0);

    // Reset mid-transaction
    push(8'h48, 0); push(8'h01, 0); push(8'hC3, 1);
    begin
      int n = 0;
      while (!tx_data_ready && n < 50) begin tick(); n++; end
    end
    for (int i = 0; i < 2; i++) begin
      check_eq("rst_mid_data", tx_data, q[0][7:0]);
      tx_data_req = 1'b1;
      tick();
      tx_data_req = 1'b0;
      void'(q.pop_front());
    end
    rst_n = 1'b0;
    #1;
    model_clear();
    check_eq("rm_ready", tx_data_ready, 0);
    check_eq("rm_tx_en", tx_en, 0);
    check_eq("rm_busy", busy, 0);
    check_eq("rm_tx_data", tx_data, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("rm_tx_en_up", tx_en, 1);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check_eq("stray_done", txn_done, 0);
    tx_data_req = 1'b1;
    tick();
    tx_data_req = 1'b0;
    check_eq("stray_req_busy", busy, 0);
    push(8'h55, 1);
    xmit(-1);

    // Randomized transactions
    for (int it = 0; it < 30; it++) begin
      int ntx = $urandom_range(1, 2);
      for (int t = 0; t < ntx; t++) begin
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) push(8'($urandom), b == len - 1);
      end
      repeat (ntx) xmit(-1);
    end
    check_eq("rand_ovf", overflow, ovf_m);
    check_eq("rand_dl", deadlock, dl_m);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_tx_feeder.md
# i2c_tx_feeder

Byte-stream buffer and transaction framer directly upstream of the serial controller's I2C byte transmitter. It accepts bytes from the configuration logic, each tagged with an end-of-transaction flag, into a small FIFO. It starts a transmitter transaction only once a complete transaction is buffered, and holds `tx_data_ready` so the transmitter chains exactly the bytes of that transaction before issuing STOP. This guarantees no mid-transaction underrun, and therefore no truncated I2C write.

## Interface
- `DEPTH_LOG2`, 4: FIFO depth is 2^DEPTH_LOG2 entries, each entry 9 bits ({last, data}).
- `clk` input 1: system clock, the same clock as the transmitter.
- `rst_n` input 1: asynchronous, active-low reset.
- `wr_en` input 1: push `wr_data`/`wr_last` this cycle.
- `wr_data` input 8: byte to push. The first byte of a transaction is the address/RW byte.
- `wr_last` input 1: the pushed byte is the final byte of its transaction.
- `wr_full` output 1: FIFO full; pushes are dropped.
- `flush` input 1: request to discard all buffered bytes.
- `tx_data` output 8: byte presented to the transmitter.
- `tx_data_ready` output 1: another byte of the current or next transaction is available.
- `tx_en` output 1: transmitter enable.
- `tx_data_req` input 1: one-cycle pulse from the transmitter; it latches `tx_data` on this edge.
- `tx_done` input 1: one-cycle pulse when the transmitter finishes STOP.
- `busy` output 1: the state is not IDLE.
- `txn_done` output 1: one-cycle pulse, registered copy of `tx_done` while in WAIT_DONE.
- `overflow` output 1: sticky; a push was dropped while full.
- `deadlock` output 1: FIFO full with zero complete transactions buffered.

## Operation
- **Storage:** 2^DEPTH_LOG2 x 9 memory with asynchronous read.
  - Pointers `wr_ptr` and `rd_ptr` are DEPTH_LOG2 bits wide and wrap modulo depth.
  - `count` is DEPTH_LOG2+1 bits.
  - `tx_data` = mem[rd_ptr][7:0] combinationally.
- **Push:** occurs when `wr_en` & !`wr_full`. A push while full is dropped and sets `overflow`.
- **Pop:** occurs exactly on a clock edge where `tx_data_req`=1. A pop with the FIFO empty cannot occur by construction; if it does, it is ignored.
- **Committed counter:** `committed` (DEPTH_LOG2+1 bits) counts the `wr_last` entries currently in the FIFO.
  - Increments on a push with `wr_last`=1.
  - Decrements on a pop of an entry with last=1.
  - Both in one cycle leaves it unchanged.
- **States** (`tx_data_ready` is a decode of state plus registers):
  - IDLE: `tx_data_ready` = (`committed`!=0) & !`flush_pend`. On `tx_data_req`: pop, then go to WAIT_DONE if the popped entry has last=1, otherwise go to ACTIVE.
  - ACTIVE: `tx_data_ready`=1. The next byte is guaranteed present because the transaction is committed. On `tx_data_req`: pop, then go to WAIT_DONE if the popped entry has last=1, otherwise stay.
  - WAIT_DONE: `tx_data_ready`=0, so the transmitter issues STOP after the current byte. On `tx_done`: go to IDLE and pulse `txn_done`.
- **Output drives:**
  - `tx_en`=1 whenever `rst_n` is deasserted and `flush_pend`=0.
  - `busy` = (state != IDLE).
- **Flush:**
  - `flush` in IDLE clears the pointers, `count`, `committed`, `overflow` and `deadlock` on the next edge.
  - `flush` in ACTIVE or WAIT_DONE sets `flush_pend`. The clear executes on the first cycle back in IDLE, and `flush_pend` is then cleared.
  - Pushes in the clearing cycle are discarded.
- **Deadlock:** `deadlock` is registered: it is set when `count`==depth and `committed`==0, and it clears only on flush or reset.

## Timing
- **Reset:** all outputs low, state IDLE, pointers, `count` and `committed` at 0, `flush_pend` at 0. The exception is `tx_en`, which goes to 1 on the first edge after `rst_n` rises.
- **Start latency:**
  - The push of a `wr_last` byte updates `committed` on its edge.
  - `tx_data_ready` rises in the following cycle.
  - The transmitter raises `tx_data_req` one cycle later, and the pop occurs on that edge.
- **Data stability:**
  - `tx_data` must hold the head entry through the cycle where `tx_data_req`=1.
  - `rd_ptr` advances only on that edge.
  - A simultaneous push never alters mem[rd_ptr] unless the FIFO is empty, which is impossible here.
- **Data-ready sampling:** the transmitter samples `tx_data_ready` at the end of each byte. In ACTIVE it is high continuously, and in WAIT_DONE it is low from the cycle after the last pop.
- **Back-to-back transactions:** `tx_data_ready` for transaction N+1 may rise the cycle after the `tx_done` edge of transaction N, with no extra gap.
- **Reset mid-transaction:** the transmitter has no reset. `tx_data_ready`=0 causes it to STOP after the current byte. Its later `tx_done` and `tx_data_req` pulses arrive with the FIFO empty and are ignored.

## Test plan
- **3-byte transaction:** push 0x48, 0x01, 0xA5 (last on 0xA5).
  - Three `tx_data_req` pops in order.
  - `tx_data_ready` goes low after the third pop.
  - One `txn_done`; `committed` returns to 0.
- **Withheld start:** push 0x48 and 0x01 without last and wait 200 cycles.
  - `tx_data_ready` stays 0.
  - Pushing 0x02 with last starts the transaction.
- **Back-to-back transactions:** push {0x48,0x10 last} then {0x90 last}.
  - Two separate transactions with two `txn_done` pulses.
  - 0x90 is popped only after the first `tx_done`.
- **Full FIFO:** DEPTH_LOG2=4; push 17 bytes, none with last.
  - `wr_full`=1 after 16 pushes; the 17th is dropped.
  - `overflow`=1 and `deadlock`=1.
  - `flush` in IDLE clears everything, including `wr_full`.
- **Flush mid-transaction:** assert `flush` during ACTIVE of a 4-byte transaction.
  - The transaction completes all 4 bytes.
  - The FIFO is cleared the cycle after returning to IDLE, and the buffered next transaction is discarded.
- **Reset mid-transaction:** pull `rst_n` low after the second byte of a 3-byte transaction.
  - All outputs go low immediately.
  - After release, no pops occur, and stray `tx_done` does not pulse `txn_done`.
